// File: rtl/fft_pkg.sv
// Shared Q1.15 types and helpers for the radix-2 FFT butterfly datapath.
package fft_pkg;
  localparam int Q15_DW   = 16;
  localparam int Q15_TW_W = 32;
  localparam int RND_SH   = Q15_DW - 1;

  localparam logic signed [Q15_DW-1:0]   Q15_MAX = 16'sh7FFF;
  localparam logic signed [Q15_DW-1:0]   Q15_MIN = 16'sh8000;
  localparam logic signed [2*Q15_DW:0]   RND_K   = 33'sd1 <<< (Q15_DW - 2);

  typedef struct packed {
    logic signed [Q15_DW-1:0] re;
    logic signed [Q15_DW-1:0] im;
  } cplx_t;

  function automatic logic signed [Q15_DW-1:0] sat_q15(input logic signed [2*Q15_DW:0] v);
    if (v > 33'sd32767)       return Q15_MAX;
    else if (v < -33'sd32768) return Q15_MIN;
    else                      return v[Q15_DW-1:0];
  endfunction

  function automatic cplx_t tw_unpack(input logic [Q15_TW_W-1:0] w);
    cplx_t c;
    c.re = w[Q15_TW_W-1:Q15_TW_W/2];
    c.im = w[Q15_TW_W/2-1:0];
    return c;
  endfunction
endpackage

// File: rtl/fft_butterfly_r2_if.sv
// Input/output handshake bundle of the radix-2 butterfly.
interface fft_butterfly_r2_if #(parameter int DW = 16, parameter int TW_W = 32);
  logic                 in_valid, in_ready;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic [TW_W-1:0]      tw_data;
  logic                 out_valid, out_ready;
  logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;

  modport master (output in_valid, a_re, a_im, b_re, b_im, tw_data, out_ready,
                  input  in_ready, out_valid, x0_re, x0_im, x1_re, x1_im);
  modport slave  (input  in_valid, a_re, a_im, b_re, b_im, tw_data, out_ready,
                  output in_ready, out_valid, x0_re, x0_im, x1_re, x1_im);
endinterface

// File: rtl/cmul_q15.sv
// Two-stage Q1.15 complex multiplier t = b*w: products, then round/shift/saturate.
module cmul_q15 import fft_pkg::*; (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t t
);
  logic signed [2*Q15_DW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [2*Q15_DW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [2*Q15_DW:0]   sum_re, sum_im;
  cplx_t t_q, t_d;

  always_comb begin
    // One guard bit covers (-1)*(-1) - (x)*(y) without wrap before saturation.
    sum_re = 33'(p_rr_q) - 33'(p_ii_q) + RND_K;
    sum_im = 33'(p_ri_q) + 33'(p_ir_q) + RND_K;
    p_rr_d = p_rr_q;
    p_ii_d = p_ii_q;
    p_ri_d = p_ri_q;
    p_ir_d = p_ir_q;
    t_d    = t_q;
    if (en) begin
      p_rr_d = b.re * w.re;
      p_ii_d = b.im * w.im;
      p_ri_d = b.re * w.im;
      p_ir_d = b.im * w.re;
      t_d.re = sat_q15(sum_re >>> RND_SH);
      t_d.im = sat_q15(sum_im >>> RND_SH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ri_q <= '0;
      p_ir_q <= '0;
      t_q    <= '0;
    end else begin
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
      t_q    <= t_d;
    end
  end

  assign t = t_q;
endmodule

// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly X0/X1 = a +/- W*b, three-stage global-stall pipeline.
module fft_butterfly_r2 import fft_pkg::*; #(
  parameter int DW    = Q15_DW,
  parameter int TW_W  = Q15_TW_W,
  parameter int SCALE = 1
) (
  input logic               clk,
  input logic               rst,
  fft_butterfly_r2_if.slave bus
);
  localparam int STAGES = 3;

  logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
  cplx_t                a1_q, a1_d, a2_q, a2_d;
  cplx_t                x0_q, x0_d, x1_q, x1_d;
  cplx_t                a_in, b_in, t;
  logic                 advance;
  logic signed [DW:0]   s0_re, s0_im, s1_re, s1_im;

  function automatic logic signed [DW-1:0] fin(input logic signed [DW:0] s);
    if (SCALE != 0) return s[DW:1];
    else            return sat_q15(33'(s));
  endfunction

  assign advance      = !vld_pipe_q[STAGES] || bus.out_ready;
  assign bus.in_ready = advance;
  assign a_in.re      = bus.a_re;
  assign a_in.im      = bus.a_im;
  assign b_in.re      = bus.b_re;
  assign b_in.im      = bus.b_im;

  cmul_q15 u_cmul (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .b   (b_in),
    .w   (tw_unpack(bus.tw_data[TW_W-1:0])),
    .t   (t)
  );

  assign s0_re = (DW+1)'(a2_q.re) + (DW+1)'(t.re);
  assign s0_im = (DW+1)'(a2_q.im) + (DW+1)'(t.im);
  assign s1_re = (DW+1)'(a2_q.re) - (DW+1)'(t.re);
  assign s1_im = (DW+1)'(a2_q.im) - (DW+1)'(t.im);

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    // in_ready == advance, so in_valid alone marks a transfer here.
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.in_valid};
      a1_d       = a_in;
      a2_d       = a1_q;
      x0_d.re    = fin(s0_re);
      x0_d.im    = fin(s0_im);
      x1_d.re    = fin(s1_re);
      x1_d.im    = fin(s1_im);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.x0_re     = x0_q.re;
  assign bus.x0_im     = x0_q.im;
  assign bus.x1_re     = x1_q.re;
  assign bus.x1_im     = x1_q.im;
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Bench for fft_butterfly_r2: directed table, stall/reset sequences, random scoreboard (both SCALE values).
module tb_fft_butterfly_r2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b1;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic [31:0]        tw = '0;

  fft_butterfly_r2_if #(.DW(16), .TW_W(32)) if1 ();
  fft_butterfly_r2_if #(.DW(16), .TW_W(32)) if0 ();

  assign if1.in_valid = in_valid;  assign if0.in_valid = in_valid;
  assign if1.out_ready = out_ready; assign if0.out_ready = out_ready;
  assign if1.a_re = a_re; assign if1.a_im = a_im; assign if1.b_re = b_re; assign if1.b_im = b_im;
  assign if0.a_re = a_re; assign if0.a_im = a_im; assign if0.b_re = b_re; assign if0.b_im = b_im;
  assign if1.tw_data = tw; assign if0.tw_data = tw;

  fft_butterfly_r2 #(.DW(16), .TW_W(32), .SCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  fft_butterfly_r2 #(.DW(16), .TW_W(32), .SCALE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  int ntests = 0;
  int nfail  = 0;
  int nout   = 0;
  logic [63:0] q1[$], q0[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chkh(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint fin(input longint s, input int scale);
    return (scale != 0) ? (s >>> 1) : clamp(s);
  endfunction

  // Reference: {x0_re, x0_im, x1_re, x1_im}
  function automatic logic [63:0] model(input logic signed [15:0] ar, ai, br, bi,
                                        input logic [31:0] w, input int scale);
    logic signed [15:0] wr16, wi16;
    longint wr, wi, tr, ti, xr0, xi0, xr1, xi1;
    wr16 = w[31:16];
    wi16 = w[15:0];
    wr = wr16; wi = wi16;
    tr = clamp((longint'(br) * wr - longint'(bi) * wi + 16384) >>> 15);
    ti = clamp((longint'(br) * wi + longint'(bi) * wr + 16384) >>> 15);
    xr0 = fin(longint'(ar) + tr, scale);
    xi0 = fin(longint'(ai) + ti, scale);
    xr1 = fin(longint'(ar) - tr, scale);
    xi1 = fin(longint'(ai) - ti, scale);
    return {16'(xr0), 16'(xi0), 16'(xr1), 16'(xi1)};
  endfunction

  // Scoreboard monitor: samples away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && if1.in_ready) begin
        q1.push_back(model(a_re, a_im, b_re, b_im, tw, 1));
        q0.push_back(model(a_re, a_im, b_re, b_im, tw, 0));
      end
      if (if1.out_valid && out_ready) begin
        nout++;
        if (q1.size() == 0) chk("sb_s1_spurious", 1, 0);
        else chkh("sb_s1", {if1.x0_re, if1.x0_im, if1.x1_re, if1.x1_im}, q1.pop_front());
      end
      if (if0.out_valid && out_ready) begin
        if (q0.size() == 0) chk("sb_s0_spurious", 1, 0);
        else chkh("sb_s0", {if0.x0_re, if0.x0_im, if0.x1_re, if0.x1_im}, q0.pop_front());
      end
    end
  end

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic [31:0]        w;
    int                 scale;
    logic signed [15:0] x0r, x0i, x1r, x1i;
  } vec_t;
  vec_t tv[7];

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'sh8000;
      1:       return 16'sh7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic signed [15:0] ar, ai, br, bi, input logic [31:0] w);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; tw = w;
  endtask

  logic [64:0] snap;
  int idx, sent, cyc_n, nout0;
  logic hold_seen;

  initial begin
    tv[0] = '{1000, 0, 2000, 0, 32'h7FFF0000, 1, 1500, 0, -500, 0};
    tv[1] = '{0, 0, 2000, 0, 32'h00008000, 1, 0, -1000, 0, 1000};
    tv[2] = '{0, 0, -32768, 0, 32'h80000000, 0, 32767, 0, -32767, 0};
    tv[3] = '{0, 0, -32768, 0, 32'h80000000, 1, 16383, 0, -16384, 0};
    tv[4] = '{30000, -30000, 30000, -30000, 32'h7FFF0000, 0, 32767, -32768, 1, -1};
    tv[5] = '{0, 0, 1, 0, 32'h40000000, 0, 1, 0, -1, 0};
    tv[6] = '{0, 0, -1, 0, 32'h40000000, 0, 0, 0, 0, 0};

    // Reset state
    #12;
    chk("rst_out_valid", if1.out_valid, 0);
    chk("rst_x0_re", if1.x0_re, 0);
    chk("rst_x1_im", if0.x1_im, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("rst_in_ready", if1.in_ready, 1);

    // Directed table: exact 3-cycle latency and hand-computed results
    foreach (tv[i]) begin
      @(posedge clk); #1;
      drive(tv[i].ar, tv[i].ai, tv[i].br, tv[i].bi, tv[i].w);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); chk("lat_c1", if1.out_valid, 0);
      @(posedge clk); @(negedge clk); chk("lat_c2", if1.out_valid, 0);
      @(posedge clk); @(negedge clk); chk("lat_c3", if1.out_valid, 1);
      if (tv[i].scale != 0)
        chkh($sformatf("vec%0d", i), {if1.x0_re, if1.x0_im, if1.x1_re, if1.x1_im},
             {tv[i].x0r, tv[i].x0i, tv[i].x1r, tv[i].x1i});
      else
        chkh($sformatf("vec%0d", i), {if0.x0_re, if0.x0_im, if0.x1_re, if0.x1_im},
             {tv[i].x0r, tv[i].x0i, tv[i].x1r, tv[i].x1i});
    end

    // 8 back-to-back beats with a 5-cycle output stall
    @(posedge clk); @(posedge clk);
    idx = 0; cyc_n = 0; nout0 = nout; hold_seen = 1'b0;
    while ((idx < 8 || nout - nout0 < 8) && cyc_n < 60) begin
      @(posedge clk); #1;
      out_ready = !(cyc_n >= 6 && cyc_n < 11);
      in_valid  = (idx < 8);
      drive(16'(idx * 100), 16'(-idx * 50), 16'(1000 + idx), 16'(3 * idx), 32'h5A82A57E);
      @(negedge clk);
      if (!out_ready) begin
        chk("stall_in_ready", if1.in_ready, 0);
        if (!hold_seen) snap = {if1.out_valid, if1.x0_re, if1.x0_im, if1.x1_re, if1.x1_im};
        else chkh("stall_hold", {if1.x0_re, if1.x0_im, if1.x1_re, if1.x1_im}, snap[63:0]);
        if (hold_seen) chk("stall_vld", if1.out_valid, snap[64]);
        hold_seen = 1'b1;
      end
      if (in_valid && if1.in_ready) idx++;
      cyc_n++;
    end
    chk("stall_beats_in", idx, 8);
    chk("stall_beats_out", nout - nout0, 8);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;

    // Reset with beats in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive(16'(500 + k), 16'(k), 16'(-700), 16'(k), 32'h7FFF0000);
      in_valid = 1'b1;
    end
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_out_valid", if1.out_valid, 0);
    chk("midrst_x0_re", if1.x0_re, 0);
    chk("midrst_x1_re", if0.x1_re, 0);
    q1.delete(); q0.delete();
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("midrst_in_ready", if1.in_ready, 1);
    drive(16'sd1234, -16'sd321, 16'sd4000, 16'sd100, 32'h00007FFF);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("post_rst_c1", if1.out_valid, 0);
    @(posedge clk); @(negedge clk); chk("post_rst_c2", if1.out_valid, 0);
    @(posedge clk); @(negedge clk); chk("post_rst_c3", if1.out_valid, 1);
    chkh("post_rst_val", {if1.x0_re, if1.x0_im, if1.x1_re, if1.x1_im},
         model(16'sd1234, -16'sd321, 16'sd4000, 16'sd100, 32'h00007FFF, 1));
    @(negedge clk); chk("post_rst_single", if1.out_valid, 0);

    // Random traffic against the scoreboard
    sent = 0; cyc_n = 0;
    while (sent < 10000 && cyc_n < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(rnd16(), rnd16(), rnd16(), rnd16(), {rnd16(), rnd16()});
      @(negedge clk);
      if (in_valid && if1.in_ready) sent++;
      cyc_n++;
    end
    chk("rand_sent", sent, 10000);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    cyc_n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && cyc_n < 20) begin
      @(posedge clk); cyc_n++;
    end
    @(negedge clk);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q0", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
